// File: rtl/mult_pkg.sv
// Shared types and helpers for the chunked skip-zero multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(input int w, input int ch);
    return w / ch;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit position of the partial product a_chunk[i]*b_chunk[j].
  function automatic int pair_shift(input int i, input int j, input int a_ch, input int b_ch);
    return i * a_ch + j * b_ch;
  endfunction

endpackage

// File: rtl/mult_skip_sched.sv
// Walks the nonzero (i,j) chunk pairs, B outer and A inner, skipping zero chunks.
module mult_skip_sched
  import mult_pkg::*;
#(
  parameter int NA = 4,
  parameter int NB = 2,
  parameter int IW = 2,
  parameter int JW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [NA-1:0] za_load,
  input  logic [NB-1:0] zb_load,
  input  logic [NA-1:0] za,
  input  logic [NB-1:0] zb,
  output logic [IW-1:0] i_idx,
  output logic [JW-1:0] j_idx,
  output logic          last
);

  function automatic logic [IW-1:0] low_a(input logic [NA-1:0] m, input int lo);
    logic [IW-1:0] r;
    r = '0;
    for (int k = NA - 1; k >= 0; k--) begin
      if (m[k] && k >= lo) r = IW'(k);
    end
    return r;
  endfunction

  function automatic logic any_a(input logic [NA-1:0] m, input int lo);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NA; k++) begin
      if (m[k] && k >= lo) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [JW-1:0] low_b(input logic [NB-1:0] m, input int lo);
    logic [JW-1:0] r;
    r = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (m[k] && k >= lo) r = JW'(k);
    end
    return r;
  endfunction

  function automatic logic any_b(input logic [NB-1:0] m, input int lo);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (m[k] && k >= lo) r = 1'b1;
    end
    return r;
  endfunction

  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [IW-1:0] i_first, i_next;
  logic [JW-1:0] j_next;
  logic          i_more, j_more;

  always_comb begin
    i_first = low_a(za, 0);
    i_next  = low_a(za, int'(i_q) + 1);
    i_more  = any_a(za, int'(i_q) + 1);
    j_next  = low_b(zb, int'(j_q) + 1);
    j_more  = any_b(zb, int'(j_q) + 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
    end else if (load) begin
      i_q <= low_a(za_load, 0);
      j_q <= low_b(zb_load, 0);
    end else if (step) begin
      if (i_more) begin
        i_q <= i_next;
      end else begin
        // Inner A sweep exhausted: wrap to the first nonzero A chunk, move to next B chunk.
        i_q <= i_first;
        j_q <= j_next;
      end
    end
  end

  assign i_idx = i_q;
  assign j_idx = j_q;
  assign last  = !i_more && !j_more;

endmodule

// File: rtl/mult_param_fast.sv
// Chunked unsigned multiplier: one nonzero partial product per cycle, zero chunks skipped.
module mult_param_fast
  import mult_pkg::*;
#(
  parameter int A_W  = 32,
  parameter int B_W  = 32,
  parameter int A_CH = 8,
  parameter int B_CH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int NA  = chunk_count(A_W, A_CH);
  localparam int NB  = chunk_count(B_W, B_CH);
  localparam int IW  = idx_width(NA);
  localparam int JW  = idx_width(NB);
  localparam int PW  = A_W + B_W;
  localparam int PPW = A_CH + B_CH;

  state_t state, state_n;
  logic   load, step, last;

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [NA-1:0]  za_in, za_q;
  logic [NB-1:0]  zb_in, zb_q;
  logic [IW-1:0]  i_idx;
  logic [JW-1:0]  j_idx;

  logic [A_CH-1:0] a_chunk [NA];
  logic [B_CH-1:0] b_chunk [NB];
  logic [PPW-1:0]  pp;
  logic [PW-1:0]   pp_sh;

  for (genvar g = 0; g < NA; g++) begin : g_a
    assign za_in[g]   = |a[g*A_CH +: A_CH];
    assign a_chunk[g] = a_q[g*A_CH +: A_CH];
  end

  for (genvar g = 0; g < NB; g++) begin : g_b
    assign zb_in[g]   = |b[g*B_CH +: B_CH];
    assign b_chunk[g] = b_q[g*B_CH +: B_CH];
  end

  mult_skip_sched #(
    .NA(NA),
    .NB(NB),
    .IW(IW),
    .JW(JW)
  ) u_sched (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .za_load (za_in),
    .zb_load (zb_in),
    .za      (za_q),
    .zb      (zb_q),
    .i_idx   (i_idx),
    .j_idx   (j_idx),
    .last    (last)
  );

  always_comb begin
    pp    = PPW'(a_chunk[i_idx]) * PPW'(b_chunk[j_idx]);
    pp_sh = PW'(pp) << pair_shift(int'(i_idx), int'(j_idx), A_CH, B_CH);
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (|za_in && |zb_in) ? CALC : DONE;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      za_q    <= '0;
      zb_q    <= '0;
      product <= '0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      za_q    <= za_in;
      zb_q    <= zb_in;
      product <= '0;
    end else if (step) begin
      product <= product + pp_sh;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_param_fast.sv
// Bench for mult_param_fast: directed vectors, corner sequences and random operands vs. a model.
module tb_mult_param_fast;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;

  mult_param_fast dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          busy_n;
    int          done_c;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: nonzero 8-bit A chunks times nonzero 16-bit B chunks gives the busy cycles.
  function automatic int ref_busy(input logic [31:0] x, input logic [31:0] y);
    int na, nb;
    na = 0;
    nb = 0;
    for (int k = 0; k < 4; k++) if (((x >> (8 * k)) & 32'hFF) != 0) na++;
    for (int k = 0; k < 2; k++) if (((y >> (16 * k)) & 32'hFFFF) != 0) nb++;
    return na * nb;
  endfunction

  task automatic run_mult(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                          input int poke, input logic [63:0] exp_prod,
                          input int exp_busy, input int exp_done);
    int          busy_n, done_c;
    logic [63:0] prod;
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = 0;
    done_c = -1;
    prod = '0;
    for (int c = 1; c <= 200; c++) begin
      if (c == poke) begin
        start = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_1234;
      end else if (c == poke + 1) begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_c = c;
        prod = product;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, "_product"}, prod, exp_prod);
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    chk({nm, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    @(posedge clk); #1;
    chk({nm, "_done_single"}, 64'(done), 64'd0);
    chk({nm, "_hold_idle"}, product, exp_prod);
  endtask

  vec_t vt [5];

  initial begin
    int          pulses;
    logic [31:0] ra, rb;

    vt[0] = '{32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_000F, 1, 2};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8, 9};
    vt[2] = '{32'h0100_0001, 32'h0001_0000, 64'h0000_0100_0001_0000, 2, 3};
    vt[3] = '{32'h0000_0000, 32'h1234_5678, 64'h0, 0, 1};
    vt[4] = '{32'h0000_FF00, 32'h0000_0000, 64'h0, 0, 1};

    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int n = 0; n < 5; n++) begin
      run_mult($sformatf("vec%0d", n), vt[n].a, vt[n].b, 0, vt[n].prod, vt[n].busy_n, vt[n].done_c);
    end

    // start pulsed mid-calculation must be ignored
    run_mult("ignore_start", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 64'hFFFF_FFFE_0000_0001, 8, 9);

    // start held high: one accept per return to IDLE, done at cycles 2, 5, 8
    a = 32'd5;
    b = 32'd3;
    start = 1'b1;
    pulses = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 8; c++) begin
      if (done) pulses++;
      if (c < 8) begin
        @(posedge clk); #1;
      end
    end
    chk("held_start_pulses", 64'(pulses), 64'd3);
    chk("held_start_product", product, 64'd15);
    start = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of a calculation
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_done", 64'(done), 64'd0);
    chk("async_reset_product", product, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_mult("after_reset", 32'd2, 32'd3, 0, 64'd6, 1, 2);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) ra = ra & ~(32'hFF << (8 * k));
      for (int k = 0; k < 2; k++) if ($urandom_range(0, 3) == 0) rb = rb & ~(32'hFFFF << (16 * k));
      run_mult($sformatf("rand%0d", n), ra, rb, 0, 64'(ra) * 64'(rb),
               ref_busy(ra, rb), ref_busy(ra, rb) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_param_fast.md
MULT_PARAM_FAST -- requirements
Module: mult_param_fast

Interface
REQ-001 The block SHALL have parameter A_W, default 32, meaning operand A width in bits.
REQ-002 The block SHALL have parameter B_W, default 32, meaning operand B width in bits.
REQ-003 The block SHALL have parameter A_CH, default 8, meaning A chunk width; A_W SHALL be a multiple of A_CH; NA = A_W/A_CH.
REQ-004 The block SHALL have parameter B_CH, default 16, meaning B chunk width; B_W SHALL be a multiple of B_CH; NB = B_W/B_CH.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock, with all state changing on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, requesting a new multiply.
REQ-008 The block SHALL have port a, input, A_W bits, unsigned operand A, sampled only on an accepted start.
REQ-009 The block SHALL have port b, input, B_W bits, unsigned operand B, sampled only on an accepted start.
REQ-010 The block SHALL have port busy, output, 1 bit, high while partial products are being accumulated.
REQ-011 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking product valid.
REQ-012 The block SHALL have port product, output, A_W+B_W bits, the unsigned product register.

Function
REQ-013 The block SHALL use the FSM states IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a and b, clear product to 0, and compute the nonzero-chunk masks za[NA-1:0] and zb[NB-1:0].
REQ-015 On an accepted start, the next state SHALL be CALC if at least one A chunk and at least one B chunk are nonzero; otherwise it SHALL be DONE.
REQ-016 In CALC, the block SHALL process exactly one chunk pair (i,j) per cycle, with both chunks nonzero, by adding a_chunk[i]*b_chunk[j] << (i*A_CH + j*B_CH) into product.
REQ-017 Pair order SHALL be j (B) outer ascending and i (A) inner ascending; zero chunks SHALL be skipped with no cycle cost.
REQ-018 After the last nonzero pair, the FSM SHALL go to DONE; DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-019 Latency from the start cycle to done SHALL be popcount(za)*popcount(zb)+1 cycles, minimum 1; busy SHALL be high exactly in CALC cycles.
REQ-020 Partial-product width SHALL be A_CH+B_CH; accumulation SHALL be full width A_W+B_W and SHALL never overflow.
REQ-021 The block SHALL ignore start while in CALC or DONE, and SHALL NOT disturb the latched operands or product.
REQ-022 product SHALL hold its value in IDLE until the next accepted start.
REQ-023 start held high continuously SHALL launch back-to-back multiplies, one accepted per return to IDLE.

Reset
REQ-024 On reset=0, the block SHALL immediately force state=IDLE, busy=0, done=0, product=0 and clear the operand registers, regardless of any multiply in progress.
REQ-025 After reset deasserts, the first rising clk edge with start=1 SHALL be accepted normally.

Structure
REQ-026 Package mult_pkg SHALL hold the state enum type and the chunk-count and shift-computation helper functions.
REQ-027 Sub-module mult_skip_sched SHALL hold the current (i,j) indices and compute the next nonzero pair and a last-pair flag from za/zb using priority encoders.
REQ-028 Datapath, FSM and product register SHALL reside in mult_param_fast.

Verification (defaults)
REQ-029 With a=0x00000005, b=0x00000003, start for 1 cycle, the bench SHALL see busy for 1 cycle, done on cycle 2, product=0x000000000000000F.
REQ-030 With a=0xFFFFFFFF, b=0xFFFFFFFF, the bench SHALL see busy for 8 cycles, done on cycle 9, product=0xFFFFFFFE00000001.
REQ-031 With a=0x01000001, b=0x00010000, the bench SHALL see busy for 2 cycles, product=0x0000010000010000.
REQ-032 With a=0, b=0x12345678, the bench SHALL see busy never asserted, done on the cycle after start, product=0.
REQ-033 With start pulsed again mid-CALC of the REQ-030 case, the bench SHALL see it ignored and the REQ-030 result unchanged.
REQ-034 With reset asserted mid-CALC, the bench SHALL see busy=0, done=0, product=0 asynchronously, and a following start a=2, b=3 SHALL yield product=6.
